// File: rtl/fetch_redirect_pkg.sv
// fetch_redirect_pkg: shared types and constants for the fetch/redirect unit
package fetch_redirect_pkg;
  localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
  typedef enum logic [1:0] {REQ, HOLD, DISCARD} fetch_state_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_data_t;
  function automatic logic [63:0] align4(input logic [63:0] a);
    return a & ~64'h3;
  endfunction
endpackage

// File: rtl/fetch_redirect_if.sv
// fetch_if: execute redirect, decode handoff and instruction-bus signals of the fetch unit
interface fetch_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        fetch_valid;
  logic [63:0] fetch_pc;
  logic [31:0] fetch_instr;
  modport master (
    input  redirect_valid, redirect_pc, stall, iresp_data_ok, iresp_data,
    output ireq_valid, ireq_addr, fetch_valid, fetch_pc, fetch_instr
  );
  modport slave (
    output redirect_valid, redirect_pc, stall, iresp_data_ok, iresp_data,
    input  ireq_valid, ireq_addr, fetch_valid, fetch_pc, fetch_instr
  );
endinterface

// File: rtl/fetch_redirect.sv
// fetch_redirect: owns the fetch PC, issues one bus request at a time and applies execute redirects
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
  input logic      clk,
  input logic      reset,
  fetch_if.master  bus
);
  fetch_state_t state_q;
  fetch_data_t  buf_q;
  logic [63:0]  pc_q, pend_pc_q, ireq_addr_q, rpc, hold_pc, disc_pc;
  logic         ireq_valid_q;
  assign rpc     = align4(bus.redirect_pc);
  assign hold_pc = bus.redirect_valid ? rpc : pc_q + 64'd4;
  assign disc_pc = bus.redirect_valid ? rpc : pend_pc_q;
  // A redirect while a request is outstanding parks the target in pend_pc until the bus answers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q      <= REQ;
      pc_q         <= PC_RESET;
      pend_pc_q    <= '0;
      ireq_valid_q <= 1'b0;
      ireq_addr_q  <= '0;
      buf_q        <= '0;
    end else
      case (state_q)
        REQ: begin
          ireq_valid_q <= 1'b1;
          ireq_addr_q  <= pc_q;
          if (bus.redirect_valid && bus.iresp_data_ok) begin
            pc_q        <= rpc;
            ireq_addr_q <= rpc;
          end else if (bus.redirect_valid) begin
            state_q   <= DISCARD;
            pend_pc_q <= rpc;
          end else if (bus.iresp_data_ok) begin
            state_q      <= HOLD;
            ireq_valid_q <= 1'b0;
            buf_q        <= '{valid: 1'b1, pc: pc_q, instr: bus.iresp_data};
          end
        end
        HOLD:
          if (bus.redirect_valid || !bus.stall) begin
            state_q      <= REQ;
            pc_q         <= hold_pc;
            ireq_valid_q <= 1'b1;
            ireq_addr_q  <= hold_pc;
            buf_q.valid  <= 1'b0;
          end
        DISCARD:
          if (bus.iresp_data_ok) begin
            state_q     <= REQ;
            pc_q        <= disc_pc;
            ireq_addr_q <= disc_pc;
          end else if (bus.redirect_valid)
            pend_pc_q <= rpc;
        default: state_q <= REQ;
      endcase
  assign bus.ireq_valid  = ireq_valid_q;
  assign bus.ireq_addr   = ireq_addr_q;
  assign bus.fetch_valid = buf_q.valid;
  assign bus.fetch_pc    = buf_q.pc;
  assign bus.fetch_instr = buf_q.instr;
  a_no_resp_in_hold: assert property (@(posedge clk) disable iff (!reset)
    !(state_q == HOLD && bus.iresp_data_ok));
endmodule

// File: tb/tb_fetch_redirect.sv
// tb_fetch_redirect: directed vector table plus reset/wrap sequences for fetch_redirect
module tb_fetch_redirect;
  localparam logic [63:0] A = 64'h0000_0000_8000_0000;
  localparam logic [63:0] W = 64'hFFFF_FFFF_FFFF_FFFC;
  logic clk, reset;
  int checks, errors;
  fetch_if bi ();
  fetch_if bw ();
  fetch_redirect dut (.clk(clk), .reset(reset), .bus(bi));
  fetch_redirect #(.PC_RESET(W)) dut_w (.clk(clk), .reset(reset), .bus(bw));
  typedef struct {
    logic        redir;
    logic [63:0] rpc;
    logic        stall;
    logic        dok;
    logic [31:0] data;
    logic        e_iv;
    logic [63:0] e_addr;
    logic        e_fv;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;
  vec_t vq[$];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic redir, input logic [63:0] rpc, input logic stall,
                              input logic dok, input logic [31:0] data, input logic e_iv,
                              input logic [63:0] e_addr, input logic e_fv, input logic [63:0] e_pc,
                              input logic [31:0] e_instr);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.stall = stall; v.dok = dok; v.data = data;
    v.e_iv = e_iv; v.e_addr = e_addr; v.e_fv = e_fv; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    bi.redirect_valid = 1'b0; bi.redirect_pc = '0; bi.stall = 1'b0;
    bi.iresp_data_ok = 1'b0; bi.iresp_data = '0;
    bw.redirect_valid = 1'b0; bw.redirect_pc = '0; bw.stall = 1'b0;
    bw.iresp_data_ok = 1'b0; bw.iresp_data = '0;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    idle_inputs();
    // first fetch, then decode accepts immediately
    vq.push_back(mk(0, 0, 0, 0, 0, 1, A, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, A, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, A, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 32'h13, 0, 0, 1, A, 32'h13));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, A + 4, 0, 0, 0));
    // five stalled cycles in HOLD
    vq.push_back(mk(0, 0, 0, 0, 0, 1, A + 4, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 32'h0010_0093, 0, 0, 1, A + 4, 32'h0010_0093));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, A + 4, 32'h0010_0093));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, A + 8, 0, 0, 0));
    // redirect while pending: old address held, response dropped
    vq.push_back(mk(1, A + 64'h100, 0, 0, 0, 1, A + 8, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, A + 8, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, A + 8, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, A + 8, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 32'hDEAD_BEEF, 1, A + 64'h100, 0, 0, 0));
    // further redirects during DISCARD: latest wins
    vq.push_back(mk(1, A + 64'h300, 0, 0, 0, 1, A + 64'h100, 0, 0, 0));
    vq.push_back(mk(1, A + 64'h100, 0, 0, 0, 1, A + 64'h100, 0, 0, 0));
    vq.push_back(mk(1, A + 64'h200, 0, 0, 0, 1, A + 64'h100, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 32'h1111_1111, 1, A + 64'h200, 0, 0, 0));
    // redirect coincident with data_ok, in REQ and in DISCARD
    vq.push_back(mk(1, A + 64'h400, 0, 1, 32'hBEEF, 1, A + 64'h400, 0, 0, 0));
    vq.push_back(mk(1, A + 64'h500, 0, 0, 0, 1, A + 64'h400, 0, 0, 0));
    vq.push_back(mk(1, A + 64'h600, 0, 1, 32'h2222, 1, A + 64'h600, 0, 0, 0));
    // redirect in HOLD, unaligned target
    vq.push_back(mk(0, 0, 0, 1, 32'h13, 0, 0, 1, A + 64'h600, 32'h13));
    vq.push_back(mk(1, A + 64'h103, 0, 0, 0, 1, A + 64'h100, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, A + 64'h100, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 32'h77, 0, 0, 1, A + 64'h100, 32'h77));
    vq.push_back(mk(1, A + 64'h700, 1, 0, 0, 1, A + 64'h700, 0, 0, 0));
    #2;
    chk("reset ireq_valid", 64'(bi.ireq_valid), 0);
    chk("reset ireq_addr", bi.ireq_addr, 0);
    chk("reset fetch_valid", 64'(bi.fetch_valid), 0);
    chk("reset fetch_pc", bi.fetch_pc, 0);
    chk("reset fetch_instr", 64'(bi.fetch_instr), 0);
    tick();
    tick();
    reset = 1'b1;
    foreach (vq[i]) begin
      bi.redirect_valid = vq[i].redir;
      bi.redirect_pc    = vq[i].rpc;
      bi.stall          = vq[i].stall;
      bi.iresp_data_ok  = vq[i].dok;
      bi.iresp_data     = vq[i].data;
      tick();
      chk($sformatf("v%0d ireq_valid", i), 64'(bi.ireq_valid), 64'(vq[i].e_iv));
      if (vq[i].e_iv) chk($sformatf("v%0d ireq_addr", i), bi.ireq_addr, vq[i].e_addr);
      chk($sformatf("v%0d fetch_valid", i), 64'(bi.fetch_valid), 64'(vq[i].e_fv));
      if (vq[i].e_fv) begin
        chk($sformatf("v%0d fetch_pc", i), bi.fetch_pc, vq[i].e_pc);
        chk($sformatf("v%0d fetch_instr", i), 64'(bi.fetch_instr), 64'(vq[i].e_instr));
      end
    end
    idle_inputs();
    // asynchronous reset in the middle of a cycle while a request is outstanding
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("async ireq_valid", 64'(bi.ireq_valid), 0);
    chk("async ireq_addr", bi.ireq_addr, 0);
    chk("async fetch_pc", bi.fetch_pc, 0);
    chk("async fetch_instr", 64'(bi.fetch_instr), 0);
    chk("async wrap ireq_valid", 64'(bw.ireq_valid), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("rerun ireq_valid", 64'(bi.ireq_valid), 1);
    chk("rerun ireq_addr", bi.ireq_addr, A);
    chk("wrap first ireq_valid", 64'(bw.ireq_valid), 1);
    chk("wrap first ireq_addr", bw.ireq_addr, W);
    bw.iresp_data_ok = 1'b1;
    bw.iresp_data    = 32'h0000_0013;
    tick();
    bw.iresp_data_ok = 1'b0;
    chk("wrap hold ireq_valid", 64'(bw.ireq_valid), 0);
    chk("wrap hold fetch_valid", 64'(bw.fetch_valid), 1);
    chk("wrap hold fetch_pc", bw.fetch_pc, W);
    tick();
    chk("wrap second ireq_valid", 64'(bw.ireq_valid), 1);
    chk("wrap second ireq_addr", bw.ireq_addr, 0);
    chk("wrap second fetch_valid", 64'(bw.fetch_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
